// File: rtl/uart_byte_tx.sv
// UART byte transmitter: 8N1 frames by default, 8E1 when UART_TX_PARITY_EN is defined.
// Valid/ready: i_tx_start is taken only while o_tx_busy=0; o_uart_tx_done pulses once per completed frame.
module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       i_sysclk,
    input  logic       i_sysrst_n,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_uart_tx,
    output logic       o_tx_busy,
    output logic       o_uart_tx_done,
    output logic [2:0] o_dbg_state
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int TW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(BIT_CYCLES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          r_done;
    logic          w_bit_end;

    assign w_bit_end = (r_timer == LAST_TICK);

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // The line is loaded on the same edge the state changes, so each bit lasts exactly BIT_CYCLES.
            if (r_state != S_IDLE) begin
                r_timer <= w_bit_end ? '0 : r_timer + TW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    if (i_tx_start) begin
                        r_shift <= i_tx_data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_idx   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= ^r_shift;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_uart_tx      = r_tx;
    assign o_tx_busy      = r_busy;
    assign o_uart_tx_done = r_done;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomized bench for uart_byte_tx against a frame-level timing model and a line decoder.
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_byte_tx;

    localparam int CLK_FREQ = 200;
    localparam int BAUD     = 20;
    localparam int BC       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       o_uart_tx;
    logic       o_tx_busy;
    logic       o_uart_tx_done;
    logic [2:0] o_dbg_state;

    int unsigned total = 0;
    int unsigned bad   = 0;

    uart_byte_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .i_sysclk       (clk),
        .i_sysrst_n     (rst_n),
        .i_tx_start     (start),
        .i_tx_data      (data),
        .o_uart_tx      (o_uart_tx),
        .o_tx_busy      (o_tx_busy),
        .o_uart_tx_done (o_uart_tx_done),
        .o_dbg_state    (o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is NB bit slots of BC clocks counted from the accepting edge.
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_byte   = 8'h00;
    int         m_done_cnt = 0;
    int         dut_done_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == NB * BC) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_done_cnt++;
                    exp_q.push_back(m_byte);
                end
            end else if (start) begin
                m_active = 1'b1;
                m_k      = 0;
                m_byte   = data;
            end
        end
    end

    function automatic logic exp_line();
        int j;
        if (!m_active) return 1'b1;
        j = m_k / BC;
        if (j == 0) return 1'b0;
        if (j <= 8) return m_byte[j-1];
        if (NB == 11 && j == 9) return ^m_byte;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("line", o_uart_tx, exp_line());
        check("busy", o_tx_busy, m_active);
        check("done", o_uart_tx_done, m_done);
    end

    // Line decoder: samples mid-bit after seeing a start edge.
    bit         obs_on = 1'b0;
    int         obs_cnt = 0;
    logic [7:0] obs_byte = 8'h00;
    logic [7:0] obs_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            obs_on = 1'b0;
        end else if (!obs_on) begin
            if (!o_uart_tx) begin
                obs_on  = 1'b1;
                obs_cnt = 0;
            end
        end else begin
            int j;
            obs_cnt++;
            if (obs_cnt >= BC + BC / 2 && (obs_cnt - BC / 2) % BC == 0) begin
                j = (obs_cnt - BC / 2) / BC - 1;
                if (j < 8) obs_byte[j] = o_uart_tx;
            end
            if (obs_cnt == BC * (NB - 1) + BC / 2) begin
                check("stop_bit", o_uart_tx, 1'b1);
                obs_q.push_back(obs_byte);
                obs_on = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (o_uart_tx_done) begin
            dut_done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else if (obs_q.size() == 0) begin
                check("no_decoded_byte", 0, 1);
                void'(exp_q.pop_front());
            end else begin
                check("rx_byte", obs_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        start = 1'b1;
        data  = b;
        repeat (hold) @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < (NB + 2) * BC; i++) begin
            @(negedge clk);
            if (o_uart_tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("timeout_done", 0, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line", o_uart_tx, 1'b1);
        check("rst_busy", o_tx_busy, 1'b0);
        check("rst_done", o_uart_tx_done, 1'b0);
        rst_n = 1'b1;

        send(8'h55, 1);
        wait_done();
        send(8'hAA, 1);
        wait_done();

        // Strobe with a different byte mid bit 4 of a frame in flight.
        send(8'h3C, 1);
        repeat (5 * BC + BC / 2 - 1) @(negedge clk);
        start = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2 * BC) @(negedge clk);
        check("no_second_frame", o_tx_busy, 1'b0);

        // Asynchronous reset during data bit 2.
        send(8'hC3, 1);
        repeat (3 * BC + 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_line", o_uart_tx, 1'b1);
        check("midrst_busy", o_tx_busy, 1'b0);
        check("midrst_done", o_uart_tx_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(8'h81, 1);
        wait_done();

        // Back-to-back: second start held across the done cycle.
        send(8'h12, 1);
        repeat (NB * BC - 3) @(negedge clk);
        start = 1'b1;
        data  = 8'h34;
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("b2b_busy", o_tx_busy, 1'b1);
        wait_done();

        // Long start strobe launches one frame only.
        send(8'h96, 3 * BC);
        wait_done();
        repeat (3) @(negedge clk);
        check("long_start_idle", o_tx_busy, 1'b0);

        for (int n = 0; n < 20; n++) begin
            send(8'($urandom), $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, (NB - 1) * BC - 6)) @(negedge clk);
                start = 1'b1;
                data  = 8'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (2 * BC) @(negedge clk);
        check("done_count", dut_done_cnt, m_done_cnt);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial UART byte transmitter producing 8N1 frames (optionally 8E1) on a single TX line. It is the upstream partner of `uart_byte_rx`: its `o_uart_tx` drives the line that `uart_byte_rx` samples, and it is used for loopback testing of the receive path. A parallel byte is accepted with a one-cycle start strobe, then shifted out LSB-first at the configured baud rate. The frame ends with a one-cycle done pulse.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. `BIT_CYCLES = CLK_FREQ/BAUD`, integer-truncated; 5208 at the defaults.
- `i_sysclk`, in, 1: system clock. All logic is on the rising edge.
- `i_sysrst_n`, in, 1: reset, asynchronous and active-low.
- `i_tx_start`, in, 1: start strobe. Sampled only in IDLE.
- `i_tx_data`, in, 8: byte to send. Captured on the accepted start edge.
- `o_uart_tx`, out, 1: serial line, registered. Idle level is 1.
- `o_tx_busy`, out, 1: high from the accepting edge until the frame completes.
- `o_uart_tx_done`, out, 1: one-cycle pulse at frame completion.

## Operation
- **States:** IDLE, START, DATA, PARITY (only with the macro), STOP. The encoding is binary.
- **IDLE:**
  - `o_uart_tx`=1, `o_tx_busy`=0.
  - When `i_tx_start`=1 at an edge: latch `i_tx_data` into the shift register, clear the bit timer, go to START.
- **START:** `o_uart_tx`=0 for `BIT_CYCLES` cycles, then go to DATA with the bit index at 0.
- **DATA:**
  - `o_uart_tx` = `shift[idx]`, LSB first, held `BIT_CYCLES` cycles per bit.
  - After bit 7, go to PARITY (macro defined) or STOP (macro undefined).
- **PARITY:** `o_uart_tx` = XOR of the latched byte (even parity) for `BIT_CYCLES` cycles, then go to STOP.
- **STOP:** `o_uart_tx`=1 for `BIT_CYCLES` cycles, then go to IDLE.
- **Bit timer:**
  - Counts 0..`BIT_CYCLES`-1 and wraps to 0 on every bit boundary.
  - Width is `$clog2(BIT_CYCLES)`.
  - It is held at 0 in IDLE.
- **Bit index:** 3 bits, counts 0..7, cleared on entry to DATA.
- **Start while busy:** ignored, no queuing. `i_tx_data` changes while busy have no effect on the frame in flight.
- **Reset:** asserting `i_sysrst_n` mid-frame immediately forces IDLE. The line goes to 1 and busy and done go to 0. The partial frame is abandoned, with no done pulse.
- **Reset values:** `o_uart_tx`=1, `o_tx_busy`=0, `o_uart_tx_done`=0. The state register, timer, index and shift register are all 0.

## Timing
- **Start acceptance:** `i_tx_start` high at edge E0 in IDLE means `o_uart_tx`=0 and `o_tx_busy`=1 from E0 onward. Latency is 1 clock from the strobe to the line falling.
- **Bit duration:** each bit is exactly `BIT_CYCLES` clocks; 104,160 ns at the defaults.
- **Frame length:** 10×`BIT_CYCLES` clocks, or 11×`BIT_CYCLES` clocks with parity.
- **Frame end:**
  - At edge E0 + 10×`BIT_CYCLES`, or E0 + 11×`BIT_CYCLES` with parity, the FSM enters IDLE.
  - At that same edge `o_tx_busy` falls and `o_uart_tx_done` rises.
  - `o_uart_tx_done` falls at the next edge.
- **Back-to-back:** a start held high during the done cycle is accepted at the following edge. The idle gap is then 1 clock, the minimum.
- **Start width:** a start held high for several cycles launches exactly one frame; further frames launch only when IDLE is revisited.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is compiled in. Frames are 8E1, with the even parity bit between data bit 7 and stop. Frame length is 11 bits.
- **Undefined:** the PARITY state and parity XOR are absent. Frames are 8N1, 10 bits. This matches the default `uart_byte_rx` format.

## Test plan
- **0x55 at defaults, 8N1:** start at t0 produces line 0,1,0,1,0,1,0,1,0,1, each bit 5208 clocks. Done pulses once, 52,080 clocks after acceptance.
- **0xAA loopback into `uart_byte_rx`:** `o_rx_data`=0xAA and `o_uart_rx_done` pulses. The TX done pulse precedes or coincides within one stop bit.
- **Start pulse while busy (0x3C frame in flight, strobe with 0xFF at mid bit 4):** the line carries only 0x3C, exactly one done pulse, and no second frame.
- **Reset mid-frame (async low during data bit 2):** the line is 1 within the same cycle, busy=0, no done. After release, a new 0x81 frame transmits correctly.
- **Back-to-back 0x12 then 0x34, second start held high through the done cycle:** the second start bit begins 1 clock after done. Both bytes decode correctly.
- **`UART_TX_PARITY_EN` defined:** 0x07 gives parity bit 1 and 0x03 gives parity bit 0. Frame length is 57,288 clocks, and done asserts at the end of the 11th bit.
